// File: rtl/windower_pkg.sv
// rtl/windower_pkg.sv - shared types and geometry helpers for the stream windower
package windower_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Zero samples padded on each side of the frame.
    function automatic int calc_pad(input int window, input int padding);
        return (padding != 0) ? (window - 1) / 2 : 0;
    endfunction

    // Beats that must be seen before the first span is complete.
    function automatic int calc_lag(input int window, input int throughput, input int padding);
        int reach;
        reach = (padding != 0) ? (window - 1) / 2 : window - 1;
        return (reach + throughput - 1) / throughput;
    endfunction

    // Samples covered by one output span (THROUGHPUT adjacent windows).
    function automatic int calc_span(input int window, input int throughput);
        return window + throughput - 1;
    endfunction

    // History depth: the newest complete span ends LAG*T-(W-1)+P samples behind
    // the newest sample, so the span always sits at the oldest end of the history.
    function automatic int calc_depth(input int window, input int throughput, input int padding);
        return calc_lag(window, throughput, padding) * throughput - (window - 1)
               + calc_pad(window, padding) + calc_span(window, throughput);
    endfunction

endpackage

// File: rtl/windower_stream_shift.sv
// rtl/windower_stream_shift.sv - sample history that shifts in one beat at a time
module window_shift_reg #(
    parameter int DATA_W     = 2,
    parameter int THROUGHPUT = 1,
    parameter int DEPTH      = 3,
    parameter int SPAN       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         shift_i,
    input  logic                         zero_i,
    input  logic [THROUGHPUT*DATA_W-1:0] data_i,
    output logic [SPAN*DATA_W-1:0]       span_o
);

    typedef logic [DATA_W-1:0] sample_t;

    // Index 0 is the oldest sample; new beats enter at the top.
    sample_t [DEPTH-1:0]          hist_q;
    sample_t [DEPTH-1:0]          hist_d;
    logic [THROUGHPUT*DATA_W-1:0] incoming;

    // Next history: shift by one beat of data or of injected zeros.
    always_comb begin
        incoming = zero_i ? '0 : data_i;
        hist_d   = hist_q;
        if (shift_i) begin
            hist_d = {incoming, hist_q[DEPTH-1:THROUGHPUT]};
        end
    end

    // The span is taken from the post-shift history so it can be registered
    // on the same edge as the shift that completes it.
    assign span_o = hist_d[SPAN-1:0];

    // History register; clearing gives the zero left padding of the next frame.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/windower_stream.sv
// rtl/windower_stream.sv - streaming 1-D conv windower with ready/valid backpressure
module windower_stream
    import windower_pkg::*;
#(
    parameter int DATA_W       = 2,
    parameter int THROUGHPUT   = 1,
    parameter int WINDOW       = 3,
    parameter int PADDING      = 1,
    parameter int LOG2_MAX_LEN = 10
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [LOG2_MAX_LEN:0]                      frame_len,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [THROUGHPUT*DATA_W-1:0]               in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [(WINDOW+THROUGHPUT-1)*DATA_W-1:0]    out_data,
    output logic                                       out_first,
    output logic                                       out_last
);

    localparam int SPAN   = calc_span(WINDOW, THROUGHPUT);
    localparam int LAG    = calc_lag(WINDOW, THROUGHPUT, PADDING);
    localparam int DEPTH  = calc_depth(WINDOW, THROUGHPUT, PADDING);
    localparam int LOG2_T = $clog2(THROUGHPUT);
    localparam int CW     = LOG2_MAX_LEN + 1;

    state_t                 state_q, state_d;
    logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]          n_beats_q, n_beats_d;
    logic [CW-1:0]          flush_cnt_q, flush_cnt_d;
    logic                   first_pend_q, first_pend_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_first_q, out_first_d;
    logic                   out_last_q, out_last_d;
    logic [SPAN*DATA_W-1:0] out_data_q, out_data_d;

    logic                   out_free, accept, accept_last;
    logic                   flush_shift, flush_done, produce, shift_en, clear_hist;
    logic [CW-1:0]          n_cur, beat_idx, beat_inc;
    logic [SPAN*DATA_W-1:0] span_next;

    window_shift_reg #(
        .DATA_W     (DATA_W),
        .THROUGHPUT (THROUGHPUT),
        .DEPTH      (DEPTH),
        .SPAN       (SPAN)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_hist),
        .shift_i (shift_en),
        .zero_i  (state_q == FLUSH),
        .data_i  (in_data),
        .span_o  (span_next)
    );

    // Handshake decode: what moves this cycle and whether it yields a span.
    always_comb begin
        out_free    = !out_valid_q || out_ready;
        in_ready    = !rst && (state_q != FLUSH) && ((state_q == FILL) || out_free);
        accept      = in_valid && in_ready;
        n_cur       = (state_q == IDLE) ? (frame_len >> LOG2_T) : n_beats_q;
        beat_idx    = (state_q == IDLE) ? '0 : beat_cnt_q;
        beat_inc    = beat_idx + CW'(1);
        accept_last = accept && (beat_inc == n_cur);
        flush_shift = (state_q == FLUSH) && out_free;
        flush_done  = flush_shift && (flush_cnt_q == CW'(LAG - 1));
        produce     = (accept && (beat_idx >= CW'(LAG))) || flush_shift;
        shift_en    = accept || flush_shift;
        clear_hist  = (PADDING != 0) ? flush_done : accept_last;
    end

    // Frame sequencing: fill the lag, stream spans, then flush trailing zeros.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        n_beats_d    = n_beats_q;
        flush_cnt_d  = flush_cnt_q;
        first_pend_d = first_pend_q;
        case (state_q)
            IDLE, FILL, RUN: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        n_beats_d    = n_cur;
                        first_pend_d = 1'b1;
                    end
                    if (accept_last) begin
                        beat_cnt_d  = '0;
                        flush_cnt_d = '0;
                        state_d     = (PADDING != 0) ? FLUSH : IDLE;
                    end else begin
                        beat_cnt_d = beat_inc;
                        state_d    = (beat_inc >= CW'(LAG)) ? RUN : FILL;
                    end
                end
            end
            FLUSH: begin
                if (flush_shift) begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                    if (flush_done) begin
                        flush_cnt_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (produce) begin
            first_pend_d = 1'b0;
        end
    end

    // Output register: load on a new span, drop valid on a bare handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = span_next;
            out_first_d = first_pend_q || (state_q == IDLE);
            out_last_d  = (PADDING != 0) ? flush_done : accept_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            n_beats_q    <= '0;
            flush_cnt_q  <= '0;
            first_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            n_beats_q    <= n_beats_d;
            flush_cnt_q  <= flush_cnt_d;
            first_pend_q <= first_pend_d;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_windower_stream.sv
// tb/tb_windower_stream.sv - scoreboard bench for three windower configurations
module tb_windower_stream;

    localparam int DW  = 8;
    localparam int LML = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [LML:0] frame_len;
    logic [15:0] in_data;
    logic        iv[3];
    logic        ordy[3];
    logic        ir[3];
    logic        ov[3];
    logic        ofst[3];
    logic        olst[3];
    logic [31:0] od[3];
    logic [23:0] od_a, od_c;
    logic [31:0] od_b;
    logic        stall_en[3];

    always #5 clk = ~clk;

    assign od[0] = {8'h00, od_a};
    assign od[1] = od_b;
    assign od[2] = {8'h00, od_c};

    windower_stream #(.DATA_W(DW), .THROUGHPUT(1), .WINDOW(3), .PADDING(1), .LOG2_MAX_LEN(LML)) u_a (
        .clk(clk), .rst(rst), .frame_len(frame_len), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(in_data[7:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a),
        .out_first(ofst[0]), .out_last(olst[0]));

    windower_stream #(.DATA_W(DW), .THROUGHPUT(2), .WINDOW(3), .PADDING(1), .LOG2_MAX_LEN(LML)) u_b (
        .clk(clk), .rst(rst), .frame_len(frame_len), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(in_data[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b),
        .out_first(ofst[1]), .out_last(olst[1]));

    windower_stream #(.DATA_W(DW), .THROUGHPUT(1), .WINDOW(3), .PADDING(0), .LOG2_MAX_LEN(LML)) u_c (
        .clk(clk), .rst(rst), .frame_len(frame_len), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(in_data[7:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_c),
        .out_first(ofst[2]), .out_last(olst[2]));

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    typedef struct {
        int          dut;
        int          len;
        int          start;
        int          nsamp;
        logic        stall;
        int          mspan;
        int          nspan;
        int          exp_stalls;
        logic [31:0] sp[8];
    } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        mon_e;
    logic        mon_ok;
    logic        prev_hold[3];
    logic [31:0] prev_d[3];
    logic [1:0]  prev_f[3];
    int          vectors = 0;
    int          errors  = 0;
    int          stall_ph;
    vec_t        vt[7];
    logic [7:0]  smp[16];
    int          st;

    function automatic logic [31:0] s3(input int a, input int b, input int c);
        logic [7:0] a8, b8, c8;
        a8 = 8'(a); b8 = 8'(b); c8 = 8'(c);
        return {8'h00, c8, b8, a8};
    endfunction

    function automatic logic [31:0] s4(input int a, input int b, input int c, input int d);
        logic [7:0] a8, b8, c8, d8;
        a8 = 8'(a); b8 = 8'(b); c8 = 8'(c); d8 = 8'(d);
        return {d8, c8, b8, a8};
    endfunction

    function automatic vec_t mk(input int dut, input int len, input int start, input int nsamp,
                                input logic stall, input int mspan, input int nspan, input int xst);
        vec_t v;
        v.dut = dut; v.len = len; v.start = start; v.nsamp = nsamp; v.stall = stall;
        v.mspan = mspan; v.nspan = nspan; v.exp_stalls = xst;
        for (int i = 0; i < 8; i++) v.sp[i] = '0;
        return v;
    endfunction

    function automatic int tput_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data, input logic f, input logic l);
        exp_t e;
        e.data = data; e.first = f; e.last = l;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int d, output exp_t e, output logic ok);
        ok = 1'b1;
        e.data = '0; e.first = 1'b0; e.last = 1'b0;
        case (d)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Reference spans straight from the definition: base = k*T - P, out-of-frame reads 0.
    task automatic model_push(input int d, input int len, input int pad, input logic [7:0] s[16]);
        int t, p, span, n, lag, m, pos;
        logic [31:0] data;
        t    = tput_of(d);
        p    = pad ? 1 : 0;
        span = 3 + t - 1;
        n    = len / t;
        lag  = pad ? (p + t - 1) / t : (2 + t - 1) / t;
        m    = pad ? n : n - lag;
        for (int k = 0; k < m; k++) begin
            data = '0;
            for (int j = 0; j < span; j++) begin
                pos = k * t - p + j;
                if (pos >= 0 && pos < len) data[j*8 +: 8] = s[pos];
            end
            push(d, data, k == 0, k == m - 1);
        end
    endtask

    task automatic drive(input int d, input int nsamp, input logic [7:0] s[16], output int stalls);
        int idx, guard, t;
        idx = 0; guard = 0; stalls = 0; t = tput_of(d);
        while (idx < nsamp && guard < 1000) begin
            in_data = '0;
            for (int k = 0; k < t; k++) in_data[k*8 +: 8] = s[idx + k];
            iv[d] = 1'b1;
            @(negedge clk);
            if (ir[d]) idx += t;
            else       stalls++;
            @(posedge clk); #1;
            guard++;
        end
        iv[d] = 1'b0;
        if (idx < nsamp) begin
            vectors++; errors++;
            $display("FAIL drive_timeout dut%0d: accepted %0d samples, required %0d", d, idx, nsamp);
        end
    endtask

    task automatic drain(input int d);
        int g;
        g = 0;
        while (qsize(d) != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (qsize(d) != 0) begin
            vectors++; errors++;
            $display("FAIL drain_timeout dut%0d: %0d spans outstanding, required 0", d, qsize(d));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready: always 1, or the 1,0,0,1 pattern when stalling is enabled.
    initial begin
        stall_ph = 0;
        for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
        forever begin
            @(posedge clk); #1;
            stall_ph++;
            for (int i = 0; i < 3; i++)
                ordy[i] = stall_en[i] ? ((stall_ph % 4 == 0) || (stall_ph % 4 == 3)) : 1'b1;
        end
    end

    // Output monitor: pop and compare on every handshake, check hold while stalled.
    initial begin
        for (int i = 0; i < 3; i++) prev_hold[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 3; i++) prev_hold[i] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (prev_hold[i] && ov[i]) begin
                        check($sformatf("hold_data dut%0d", i), od[i], prev_d[i]);
                        check($sformatf("hold_flags dut%0d", i), {30'd0, ofst[i], olst[i]}, {30'd0, prev_f[i]});
                    end
                    if (i < 2 && ov[i] && !ordy[i])
                        check($sformatf("in_ready_when_full dut%0d", i), {31'd0, ir[i]}, 32'd0);
                    if (ov[i] && ordy[i]) begin
                        pop_exp(i, mon_e, mon_ok);
                        if (!mon_ok) begin
                            vectors++; errors++;
                            $display("FAIL spurious_span dut%0d: got %0h, expected no span", i, od[i]);
                        end else begin
                            check($sformatf("span_data dut%0d", i), od[i], mon_e.data);
                            check($sformatf("span_first dut%0d", i), {31'd0, ofst[i]}, {31'd0, mon_e.first});
                            check($sformatf("span_last dut%0d", i), {31'd0, olst[i]}, {31'd0, mon_e.last});
                        end
                    end
                    prev_hold[i] = ov[i] && !ordy[i];
                    prev_d[i]    = od[i];
                    prev_f[i]    = {ofst[i], olst[i]};
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_len = '0; in_data = '0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; stall_en[i] = 1'b0; end

        vt[0] = mk(0, 4, 1, 4, 1'b0, 4, 4, 0);
        vt[0].sp[0] = s3(0,1,2); vt[0].sp[1] = s3(1,2,3); vt[0].sp[2] = s3(2,3,4); vt[0].sp[3] = s3(3,4,0);
        vt[1] = mk(1, 8, 1, 8, 1'b0, 4, 4, 0);
        vt[1].sp[0] = s4(0,1,2,3); vt[1].sp[1] = s4(2,3,4,5); vt[1].sp[2] = s4(4,5,6,7); vt[1].sp[3] = s4(6,7,8,0);
        vt[2] = mk(2, 5, 1, 5, 1'b0, 3, 3, 0);
        vt[2].sp[0] = s3(1,2,3); vt[2].sp[1] = s3(2,3,4); vt[2].sp[2] = s3(3,4,5);
        vt[3] = mk(0, 4, 1, 4, 1'b1, 4, 4, -1);
        vt[3].sp = vt[0].sp;
        vt[4] = mk(0, 4, 1, 8, 1'b0, 4, 8, 1);
        vt[4].sp[0] = s3(0,1,2); vt[4].sp[1] = s3(1,2,3); vt[4].sp[2] = s3(2,3,4); vt[4].sp[3] = s3(3,4,0);
        vt[4].sp[4] = s3(0,5,6); vt[4].sp[5] = s3(5,6,7); vt[4].sp[6] = s3(6,7,8); vt[4].sp[7] = s3(7,8,0);
        vt[5] = mk(2, 3, 4, 3, 1'b0, 1, 1, 0);
        vt[5].sp[0] = s3(4,5,6);
        vt[6] = mk(1, 2, 7, 2, 1'b0, 1, 1, 0);
        vt[6].sp[0] = s4(0,7,8,0);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out_valid dut%0d", i), {31'd0, ov[i]}, 32'd0);
            check($sformatf("rst_out_first dut%0d", i), {31'd0, ofst[i]}, 32'd0);
            check($sformatf("rst_out_last dut%0d", i), {31'd0, olst[i]}, 32'd0);
            check($sformatf("rst_out_data dut%0d", i), od[i], 32'd0);
            check($sformatf("rst_in_ready dut%0d", i), {31'd0, ir[i]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("in_ready_after_rst dut%0d", i), {31'd0, ir[i]}, 32'd1);
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            stall_en[vt[v].dut] = vt[v].stall;
            for (int k = 0; k < vt[v].nspan; k++)
                push(vt[v].dut, vt[v].sp[k], (k % vt[v].mspan) == 0, (k % vt[v].mspan) == vt[v].mspan - 1);
            frame_len = 11'(vt[v].len);
            for (int k = 0; k < 16; k++) smp[k] = 8'(vt[v].start + k);
            drive(vt[v].dut, vt[v].nsamp, smp, st);
            if (vt[v].exp_stalls >= 0)
                check($sformatf("in_ready_stalls vec%0d", v), 32'(st), 32'(vt[v].exp_stalls));
            drain(vt[v].dut);
            stall_en[vt[v].dut] = 1'b0;
        end

        // Reset in the middle of a frame, then a fresh frame.
        frame_len = 11'd4;
        push(0, s3(0,1,2), 1'b1, 1'b0);
        smp[0] = 8'd1; smp[1] = 8'd2;
        drive(0, 2, smp, st);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("in_ready_during_rst", {31'd0, ir[0]}, 32'd0);
        @(posedge clk); #1;
        check("out_valid_after_mid_rst", {31'd0, ov[0]}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_first_cycle", {31'd0, ir[0]}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) smp[k] = 8'(9 + k);
        push(0, s3(0,9,10), 1'b1, 1'b0);
        push(0, s3(9,10,11), 1'b0, 1'b0);
        push(0, s3(10,11,12), 1'b0, 1'b0);
        push(0, s3(11,12,0), 1'b0, 1'b1);
        drive(0, 4, smp, st);
        drain(0);

        // Random data against the reference model, with and without backpressure.
        for (int k = 0; k < 16; k++) smp[k] = 8'($urandom_range(0, 255));
        frame_len = 11'd12;
        stall_en[1] = 1'b1;
        model_push(1, 12, 1, smp);
        drive(1, 12, smp, st);
        drain(1);
        stall_en[1] = 1'b0;

        for (int k = 0; k < 16; k++) smp[k] = 8'($urandom_range(0, 255));
        frame_len = 11'd8;
        model_push(2, 8, 0, smp);
        drive(2, 8, smp, st);
        check("in_ready_stalls pad0_random", 32'(st), 32'd0);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
